// File: rtl/mod_signal_monitor.sv
// mod_signal_monitor: loopback checker for the imager CLK/CLKN/CLKL drive signals.
// For each looped-back CLK cycle it measures the period, the high time and the
// CLK-to-CLKL phase in USER_CLOCK cycles, and flags a stopped CLK (STALL).
// Optional feature macro: MON_OVERLAP_CHECK_EN builds the CLKN synchronizer and
// the sticky CLK/CLKN overlap detector; without it OVERLAP_ERR is tied low.
module mod_signal_monitor #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             USER_CLOCK,
  input  logic             RESET,
  input  logic             MEAS_EN,
  input  logic             CLEAR,
  input  logic             MBI_CLK_FB,
  input  logic             MBI_CLKN_FB,
  input  logic             MBI_CLKL_FB,
  output logic [CNT_W-1:0] PERIOD_OUT,
  output logic [CNT_W-1:0] HIGH_OUT,
  output logic [CNT_W-1:0] PHASE_OUT,
  output logic             PHASE_MISS,
  output logic             RESULT_VALID,
  output logic             STALL,
  output logic             OVERLAP_ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             clk_s1;
  logic             clk_s2;
  logic             clk_d;
  logic             clkl_s1;
  logic             clkl_s2;
  logic             clkl_d;
  logic             clk_rise;
  logic             clk_fall;
  logic             clkl_rise;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_cap;
  logic [CNT_W-1:0] phase_cap;
  logic             phase_seen;
  logic             armed;

  logic             start_cycle;
  logic             publish;
  logic             track;
  logic             stall_set;

  // Two-flop synchronizers plus edge-detect register for CLK and CLKL
  always_ff @(posedge USER_CLOCK or posedge RESET) begin
    if (RESET) begin
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      clk_d   <= 1'b0;
      clkl_s1 <= 1'b0;
      clkl_s2 <= 1'b0;
      clkl_d  <= 1'b0;
    end else begin
      clk_s1  <= MBI_CLK_FB;
      clk_s2  <= clk_s1;
      clk_d   <= clk_s2;
      clkl_s1 <= MBI_CLKL_FB;
      clkl_s2 <= clkl_s1;
      clkl_d  <= clkl_s2;
    end
  end

  assign clk_rise  = clk_s2 & ~clk_d;
  assign clk_fall  = ~clk_s2 & clk_d;
  assign clkl_rise = clkl_s2 & ~clkl_d;

  // Free-running saturating counter, restarted at 1 on every CLK rise
  always_ff @(posedge USER_CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (clk_rise) begin
      cnt <= CNT_ONE;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // FSM state register
  always_ff @(posedge USER_CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a saturated counter outranks a rise on the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT: begin
        if (MEAS_EN && clk_rise) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!MEAS_EN)            state_nxt = S_WAIT;
        else if (cnt == CNT_MAX) state_nxt = S_STALL;
      end
      S_STALL: begin
        if (!MEAS_EN)            state_nxt = S_WAIT;
        else if (clk_rise)       state_nxt = S_RUN;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // FSM control strobes for the capture and result datapath
  always_comb begin
    start_cycle = 1'b0;
    publish     = 1'b0;
    track       = 1'b0;
    stall_set   = 1'b0;
    case (state)
      S_WAIT:  start_cycle = MEAS_EN & clk_rise;
      S_RUN: begin
        if (MEAS_EN) begin
          if (cnt == CNT_MAX) stall_set = 1'b1;
          else if (clk_rise)  publish   = 1'b1;
          else                track     = 1'b1;
        end
      end
      S_STALL: start_cycle = MEAS_EN & clk_rise;
      default: ;
    endcase
  end

  // Per-period captures; a CLKL rise coinciding with the CLK rise counts as phase 0
  always_ff @(posedge USER_CLOCK or posedge RESET) begin
    if (RESET) begin
      high_cap   <= '0;
      phase_cap  <= '0;
      phase_seen <= 1'b0;
      armed      <= 1'b0;
    end else if (start_cycle || publish) begin
      high_cap   <= '0;
      phase_cap  <= '0;
      phase_seen <= clkl_rise;
      armed      <= ~clkl_rise;
    end else if (track) begin
      if (clk_fall) high_cap <= cnt;
      if (clkl_rise && armed) begin
        phase_cap  <= cnt;
        phase_seen <= 1'b1;
        armed      <= 1'b0;
      end
    end
  end

  // Result registers, updated on the cycle after the closing CLK rise
  always_ff @(posedge USER_CLOCK or posedge RESET) begin
    if (RESET) begin
      PERIOD_OUT   <= '0;
      HIGH_OUT     <= '0;
      PHASE_OUT    <= '0;
      PHASE_MISS   <= 1'b0;
      RESULT_VALID <= 1'b0;
    end else begin
      RESULT_VALID <= publish;
      if (publish) begin
        PERIOD_OUT <= cnt;
        HIGH_OUT   <= high_cap;
        PHASE_OUT  <= phase_cap;
        PHASE_MISS <= ~phase_seen;
      end
    end
  end

  // Sticky stall flag; setting wins over a simultaneous clear
  always_ff @(posedge USER_CLOCK or posedge RESET) begin
    if (RESET) begin
      STALL <= 1'b0;
    end else if (stall_set) begin
      STALL <= 1'b1;
    end else if (CLEAR) begin
      STALL <= 1'b0;
    end
  end

`ifdef MON_OVERLAP_CHECK_EN
  logic clkn_s1;
  logic clkn_s2;

  // Two-flop synchronizer for CLKN
  always_ff @(posedge USER_CLOCK or posedge RESET) begin
    if (RESET) begin
      clkn_s1 <= 1'b0;
      clkn_s2 <= 1'b0;
    end else begin
      clkn_s1 <= MBI_CLKN_FB;
      clkn_s2 <= clkn_s1;
    end
  end

  // Sticky overlap flag, independent of FSM state; setting wins over clear
  always_ff @(posedge USER_CLOCK or posedge RESET) begin
    if (RESET) begin
      OVERLAP_ERR <= 1'b0;
    end else if (clk_s2 && clkn_s2) begin
      OVERLAP_ERR <= 1'b1;
    end else if (CLEAR) begin
      OVERLAP_ERR <= 1'b0;
    end
  end
`else
  logic unused_clkn;
  assign unused_clkn = MBI_CLKN_FB;
  assign OVERLAP_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mod_signal_monitor.sv
// tb_mod_signal_monitor: self-checking bench for mod_signal_monitor.
// Feedback pins are generated cycle-synchronously; an event-level model turns
// pin edges into expected per-period results kept in a queue.
module tb_mod_signal_monitor;

  localparam int unsigned CNT_W = 16;
  localparam longint      MAXP  = (64'd1 << CNT_W) - 2;
`ifdef MON_OVERLAP_CHECK_EN
  localparam int          EXP_OVL = 1;
`else
  localparam int          EXP_OVL = 0;
`endif

  logic             USER_CLOCK = 1'b0;
  logic             RESET = 1'b1;
  logic             MEAS_EN = 1'b0;
  logic             CLEAR = 1'b0;
  logic             MBI_CLK_FB = 1'b0;
  logic             MBI_CLKN_FB = 1'b1;
  logic             MBI_CLKL_FB = 1'b0;
  logic [CNT_W-1:0] PERIOD_OUT;
  logic [CNT_W-1:0] HIGH_OUT;
  logic [CNT_W-1:0] PHASE_OUT;
  logic             PHASE_MISS;
  logic             RESULT_VALID;
  logic             STALL;
  logic             OVERLAP_ERR;

  mod_signal_monitor #(.CNT_W(CNT_W)) dut (
    .USER_CLOCK   (USER_CLOCK),
    .RESET        (RESET),
    .MEAS_EN      (MEAS_EN),
    .CLEAR        (CLEAR),
    .MBI_CLK_FB   (MBI_CLK_FB),
    .MBI_CLKN_FB  (MBI_CLKN_FB),
    .MBI_CLKL_FB  (MBI_CLKL_FB),
    .PERIOD_OUT   (PERIOD_OUT),
    .HIGH_OUT     (HIGH_OUT),
    .PHASE_OUT    (PHASE_OUT),
    .PHASE_MISS   (PHASE_MISS),
    .RESULT_VALID (RESULT_VALID),
    .STALL        (STALL),
    .OVERLAP_ERR  (OVERLAP_ERR)
  );

  initial forever #5 USER_CLOCK = ~USER_CLOCK;

  typedef struct {
    int p; int h; int d; int hl; bit lon;
    int e_period; int e_high; int e_phase; bit e_miss;
  } vec_t;

  typedef struct {
    longint period; longint high; longint phase; bit miss;
  } res_t;

  int     checks = 0;
  int     failures = 0;
  int     n_results = 0;
  res_t   exp_q[$];
  res_t   last_exp;

  // generator configuration (applied at the next CLK period boundary)
  int     gen_p = 100, gen_h = 50, gen_d = 0, gen_hl = 50;
  bit     gen_lon = 1'b1;
  bit     gen_run = 1'b0;
  bit     force_n = 1'b0;
  int     cur_p, cur_h, cur_d, cur_hl;
  bit     cur_lon;
  int     k;
  longint gtick = 0;

  // reference model state
  bit     m_on = 1'b0;
  bit     have_prev = 1'b0;
  longint prev = 0;
  longint fall_at = -1;
  longint phase_at = -1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // A CLK pin rise closes the running period when measurement was already armed
  function automatic void model_rise();
    res_t   r;
    longint p;
    if (m_on && have_prev) begin
      p = gtick - prev;
      if (p <= MAXP) begin
        r.period = p;
        r.high   = (fall_at >= 0) ? fall_at : 0;
        r.phase  = (phase_at >= 0) ? phase_at : 0;
        r.miss   = (phase_at < 0);
        exp_q.push_back(r);
      end
    end
    prev      = gtick;
    have_prev = m_on;
    fall_at   = -1;
    phase_at  = -1;
  endfunction

  function automatic void model_fall();
    if (fall_at < 0) fall_at = gtick - prev;
  endfunction

  function automatic void model_lrise();
    if (phase_at < 0) phase_at = gtick - prev;
  endfunction

  // Pin generator: one step per USER_CLOCK cycle, just after the rising edge
  initial begin : gen
    bit nc, nl, nn;
    cur_p = gen_p; cur_h = gen_h; cur_d = gen_d; cur_hl = gen_hl; cur_lon = gen_lon;
    k = cur_p - 1;
    forever begin
      @(posedge USER_CLOCK);
      #1;
      gtick++;
      nc = MBI_CLK_FB;
      nl = MBI_CLKL_FB;
      if (gen_run) begin
        k++;
        if (k >= cur_p) begin
          k = 0;
          cur_p = gen_p; cur_h = gen_h; cur_d = gen_d; cur_hl = gen_hl; cur_lon = gen_lon;
        end
        nc = (k < cur_h);
        nl = cur_lon && (((k + cur_p - cur_d) % cur_p) < cur_hl);
      end
      nn = force_n || !nc;
      if (nc && !MBI_CLK_FB) model_rise();
      if (!nc && MBI_CLK_FB) model_fall();
      if (nl && !MBI_CLKL_FB) model_lrise();
      MBI_CLK_FB  = nc;
      MBI_CLKL_FB = nl;
      MBI_CLKN_FB = nn;
    end
  end

  // Scoreboard: every RESULT_VALID must match the oldest closed period
  initial begin : mon
    res_t r;
    forever begin
      @(negedge USER_CLOCK);
      if (RESULT_VALID) begin
        n_results++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: RESULT_VALID=1 with period %0d, required no result", PERIOD_OUT);
        end else begin
          r = exp_q.pop_front();
          last_exp = r;
          check("sb_period", PERIOD_OUT, r.period);
          check("sb_high",   HIGH_OUT,   r.high);
          check("sb_phase",  PHASE_OUT,  r.phase);
          check("sb_miss",   PHASE_MISS, r.miss);
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_results(input int n, input string name);
    int target;
    bit done;
    target = n_results + n;
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge USER_CLOCK);
      if (n_results >= target) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d results, required %0d", name, n_results, target);
    end
  endtask

  task automatic wait_k(input int x);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge USER_CLOCK);
      if (gen_run && k == x) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_k_timeout: phase %0d, required %0d", k, x);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_period"}, PERIOD_OUT, 0);
    check({pfx, "_high"},   HIGH_OUT, 0);
    check({pfx, "_phase"},  PHASE_OUT, 0);
    check({pfx, "_miss"},   PHASE_MISS, 0);
    check({pfx, "_valid"},  RESULT_VALID, 0);
    check({pfx, "_stall"},  STALL, 0);
    check({pfx, "_ovl"},    OVERLAP_ERR, 0);
  endtask

  task automatic set_cfg(input int p, input int h, input int d, input int hl, input bit lon);
    gen_p = p; gen_h = h; gen_d = d; gen_hl = hl; gen_lon = lon;
  endtask

  initial begin : main
    vec_t tbl[7];
    int   n0;
    int   p, h;

    tbl[0] = '{p:100, h:50, d:0,  hl:50, lon:1, e_period:100, e_high:50, e_phase:0,  e_miss:0};
    tbl[1] = '{p:25,  h:6,  d:5,  hl:12, lon:1, e_period:25,  e_high:6,  e_phase:5,  e_miss:0};
    tbl[2] = '{p:25,  h:7,  d:5,  hl:12, lon:1, e_period:25,  e_high:7,  e_phase:5,  e_miss:0};
    tbl[3] = '{p:40,  h:10, d:0,  hl:20, lon:0, e_period:40,  e_high:10, e_phase:0,  e_miss:1};
    tbl[4] = '{p:30,  h:28, d:29, hl:1,  lon:1, e_period:30,  e_high:28, e_phase:29, e_miss:0};
    tbl[5] = '{p:12,  h:1,  d:11, hl:6,  lon:1, e_period:12,  e_high:1,  e_phase:11, e_miss:0};
    tbl[6] = '{p:100, h:50, d:0,  hl:50, lon:1, e_period:100, e_high:50, e_phase:0,  e_miss:0};

    // reset state
    repeat (3) @(negedge USER_CLOCK);
    check_zero("reset");
    RESET = 1'b0;
    MEAS_EN = 1'b1;
    m_on = 1'b1;
    gen_run = 1'b1;

    // directed waveform table
    for (int i = 0; i < 7; i++) begin
      set_cfg(tbl[i].p, tbl[i].h, tbl[i].d, tbl[i].hl, tbl[i].lon);
      wait_results(3, "tbl");
      check($sformatf("tbl%0d_period", i), PERIOD_OUT, tbl[i].e_period);
      check($sformatf("tbl%0d_high", i),   HIGH_OUT,   tbl[i].e_high);
      check($sformatf("tbl%0d_phase", i),  PHASE_OUT,  tbl[i].e_phase);
      check($sformatf("tbl%0d_miss", i),   PHASE_MISS, tbl[i].e_miss);
    end

    // randomized waveforms against the event model
    for (int i = 0; i < 10; i++) begin
      p = int'($urandom_range(150, 8));
      h = int'($urandom_range(p - 1, 1));
      set_cfg(p, h, int'($urandom_range(p - 1, 0)), int'($urandom_range(p - 1, 1)),
              ($urandom % 4) != 0);
      wait_results(3, "rnd");
    end

    // overlap: held CLEAR loses against an active overlap, then clears it
    set_cfg(100, 50, 20, 40, 1'b1);
    wait_results(2, "ovl_cfg");
    wait_k(10);
    check("ovl_before", OVERLAP_ERR, 0);
    CLEAR = 1'b1;
    force_n = 1'b1;
    repeat (8) @(negedge USER_CLOCK);
    check("ovl_set_over_clear", OVERLAP_ERR, EXP_OVL);
    force_n = 1'b0;
    repeat (6) @(negedge USER_CLOCK);
    check("ovl_held_clear", OVERLAP_ERR, 0);
    CLEAR = 1'b0;
    wait_k(10);
    force_n = 1'b1;
    repeat (10) @(negedge USER_CLOCK);
    force_n = 1'b0;
    repeat (50) @(negedge USER_CLOCK);
    check("ovl_sticky", OVERLAP_ERR, EXP_OVL);
    CLEAR = 1'b1;
    @(negedge USER_CLOCK);
    CLEAR = 1'b0;
    @(negedge USER_CLOCK);
    check("ovl_clear_pulse", OVERLAP_ERR, 0);

    // MEAS_EN dropped mid-period: results hold, nothing published
    wait_results(1, "men_pre");
    wait_k(60);
    MEAS_EN = 1'b0;
    m_on = 1'b0;
    have_prev = 1'b0;
    n0 = n_results;
    repeat (300) @(negedge USER_CLOCK);
    check("men_hold_period", PERIOD_OUT, last_exp.period);
    check("men_hold_high",   HIGH_OUT,   last_exp.high);
    check("men_hold_phase",  PHASE_OUT,  last_exp.phase);
    check("men_no_valid",    n_results - n0, 0);
    wait_k(60);
    MEAS_EN = 1'b1;
    m_on = 1'b1;
    wait_results(2, "men_resume");

    // RESET mid-period
    wait_k(60);
    RESET = 1'b1;
    m_on = 1'b0;
    have_prev = 1'b0;
    repeat (2) @(negedge USER_CLOCK);
    check_zero("rst_mid");
    RESET = 1'b0;
    m_on = 1'b1;
    wait_results(2, "rst_resume");

    // CLK stopped high: stall after the counter saturates
    wait_k(5);
    gen_run = 1'b0;
    n0 = n_results;
    repeat (65000) @(negedge USER_CLOCK);
    check("stall_early", STALL, 0);
    repeat (700) @(negedge USER_CLOCK);
    check("stall_set", STALL, 1);
    check("stall_no_valid", n_results - n0, 0);
    gen_run = 1'b1;
    wait_results(2, "stall_resume");
    check("stall_sticky", STALL, 1);
    CLEAR = 1'b1;
    @(negedge USER_CLOCK);
    CLEAR = 1'b0;
    @(negedge USER_CLOCK);
    check("stall_clear", STALL, 0);

    // drain: every closed period must have been published
    wait_k(60);
    repeat (10) @(negedge USER_CLOCK);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
